// File: rtl/rtl_settings_pkg.sv
// Shared widths, types and helpers for the memory checker datapath.
package rtl_settings_pkg;

    localparam int ADDR_W        = 32;
    localparam int AMM_ADDR_W    = 28;
    localparam int AMM_BURST_W   = 8;
    localparam int ADDR_B_W      = 4;
    localparam int DATA_B_W      = 16;
    localparam int BURST_BYTES_W = AMM_BURST_W + ADDR_B_W;

    // Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        TM_NONE         = 2'b00,
        READ_ONLY       = 2'b01,
        WRITE_ONLY      = 2'b10,
        WRITE_AND_CHECK = 2'b11
    } test_mode_t;

    typedef enum logic [2:0] {
        FIX_ADDR   = 3'd0,
        INC_ADDR   = 3'd1,
        RND_ADDR   = 3'd2,
        RUN_1_ADDR = 3'd3,
        RUN_0_ADDR = 3'd4
    } addr_mode_t;

    typedef enum logic [1:0] {
        DM_FIXED = 2'd0,
        DM_INCR  = 2'd1,
        DM_PRBS  = 2'd2,
        DM_PTRN  = 2'd3
    } data_mode_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        ISSUE_WR = 3'd2,
        ISSUE_RD = 3'd3,
        NEXT     = 3'd4,
        FIN      = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic                   trans_type;
        logic [AMM_ADDR_W-1:0]  start_addr;
        logic [ADDR_B_W-1:0]    start_off;
        logic [ADDR_B_W-1:0]    end_off;
        logic [AMM_BURST_W-1:0] words_count;
        data_mode_t             data_mode;
        logic [7:0]             data_ptrn;
    } cmp_struct_t;

    // Address/offset/count fields of one burst starting at byte address a.
    // trans_type and data fields are left zero for the caller to fill.
    function automatic cmp_struct_t calc_cmd(input logic [ADDR_W-1:0]        a,
                                             input logic [BURST_BYTES_W-1:0] burst_bytes);
        logic [ADDR_W-1:0] e;
        cmp_struct_t       c;
        e             = a + ADDR_W'(burst_bytes) - ADDR_W'(1);
        c             = '0;
        c.start_addr  = a[ADDR_W-1:ADDR_B_W];
        c.start_off   = a[ADDR_B_W-1:0];
        c.end_off     = e[ADDR_B_W-1:0];
        c.words_count = AMM_BURST_W'((e >> ADDR_B_W) - (a >> ADDR_B_W) + ADDR_W'(1));
        return c;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/test_sequencer_addr_gen.sv
// Per-iteration byte address generator: INC accumulator, LFSR and walking-bit index.
module addr_gen
    import rtl_settings_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     load_i,
    input  logic                     advance_i,
    input  addr_mode_t               mode_i,
    input  logic [ADDR_W-1:0]        start_addr_i,
    input  logic [BURST_BYTES_W-1:0] burst_i,
    output logic [ADDR_W-1:0]        addr_o
);

    localparam int              K_W    = $clog2(AMM_ADDR_W);
    localparam logic [K_W-1:0]  K_LAST = K_W'(AMM_ADDR_W - 1);

    logic [ADDR_W-1:0]   inc_q, inc_d;
    logic [31:0]         lfsr_q, lfsr_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [ADDR_B_W-1:0] off_q, off_d;
    logic [AMM_ADDR_W-1:0] walk;

    // Seed pattern state on run start, step it once per completed iteration
    always_comb begin
        inc_d  = inc_q;
        lfsr_d = lfsr_q;
        k_d    = k_q;
        off_d  = off_q;
        if (load_i) begin
            inc_d  = start_addr_i;
            off_d  = start_addr_i[ADDR_B_W-1:0];
            lfsr_d = (start_addr_i == '0) ? LFSR_SEED : 32'(start_addr_i);
            k_d    = '0;
        end else if (advance_i) begin
            if (mode_i == INC_ADDR) begin
                inc_d = inc_q + ADDR_W'(burst_i);
            end
            lfsr_d = lfsr_next(lfsr_q);
            k_d    = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
        end
    end

    // Pattern registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inc_q  <= '0;
            lfsr_q <= LFSR_SEED;
            k_q    <= '0;
            off_q  <= '0;
        end else begin
            inc_q  <= inc_d;
            lfsr_q <= lfsr_d;
            k_q    <= k_d;
            off_q  <= off_d;
        end
    end

    // Assemble the byte address; FIX holds inc_q at the start address
    always_comb begin
        walk = AMM_ADDR_W'(1) << k_q;
        case (mode_i)
            RND_ADDR:   addr_o = {lfsr_q[AMM_ADDR_W-1:0], off_q};
            RUN_1_ADDR: addr_o = {walk, off_q};
            RUN_0_ADDR: addr_o = {~walk, off_q};
            default:    addr_o = inc_q;
        endcase
    end

endmodule

// File: rtl/test_sequencer.sv
// Command scheduler: turns one latched test configuration into a stream of
// write/read burst commands with start/stop/busy/done handshaking.
//
// state    | meaning
// IDLE     | waiting for start; settings latched on accept
// LOAD     | build command for the current iteration address
// ISSUE_WR | write command presented, waiting for ready
// ISSUE_RD | read command presented, waiting for ready
// NEXT     | iteration complete, bump count, decide LOAD or FIN
// FIN      | end of run, done pulse follows
module test_sequencer
    import rtl_settings_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  test_mode_t               test_mode_i,
    input  addr_mode_t               addr_mode_i,
    input  data_mode_t               data_mode_i,
    input  logic [7:0]               data_ptrn_i,
    input  logic [ADDR_W-1:0]        start_addr_i,
    input  logic [BURST_BYTES_W-1:0] burst_bytes_i,
    input  logic [31:0]              trans_count_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output cmp_struct_t              cmd_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [31:0]              iter_cnt_o
);

    seq_state_t               state_q, state_d;
    test_mode_t               test_mode_q, test_mode_d;
    addr_mode_t               addr_mode_q, addr_mode_d;
    data_mode_t               data_mode_q, data_mode_d;
    logic [7:0]               data_ptrn_q, data_ptrn_d;
    logic [BURST_BYTES_W-1:0] bytes_q, bytes_d;
    logic [31:0]              count_q, count_d;
    logic [31:0]              iter_q, iter_d;
    cmp_struct_t              cmd_q, cmd_d;
    logic                     cmd_valid_q, cmd_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     stop_pend_q, stop_pend_d;

    logic                     start_acc;
    logic                     xfer;
    logic                     stop_any;
    logic [ADDR_W-1:0]        ag_addr;

    assign start_acc = (state_q == IDLE) && start_i && (test_mode_i != TM_NONE);
    assign xfer      = cmd_valid_q && cmd_ready_i;
    assign stop_any  = stop_i || stop_pend_q;

    addr_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_addr_gen (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .load_i       (start_acc),
        .advance_i    (state_q == NEXT),
        .mode_i       (addr_mode_q),
        .start_addr_i (start_addr_i),
        .burst_i      (bytes_q),
        .addr_o       (ag_addr)
    );

    // Sequencer next-state and output register inputs
    always_comb begin
        state_d     = state_q;
        test_mode_d = test_mode_q;
        addr_mode_d = addr_mode_q;
        data_mode_d = data_mode_q;
        data_ptrn_d = data_ptrn_q;
        bytes_d     = bytes_q;
        count_d     = count_q;
        iter_d      = iter_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start_acc) begin
                    test_mode_d = test_mode_i;
                    addr_mode_d = addr_mode_i;
                    data_mode_d = data_mode_i;
                    data_ptrn_d = data_ptrn_i;
                    bytes_d     = (burst_bytes_i == '0) ? BURST_BYTES_W'(1) : burst_bytes_i;
                    count_d     = trans_count_i;
                    iter_d      = '0;
                    busy_d      = 1'b1;
                    state_d     = (trans_count_i == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                if (stop_i) begin
                    state_d = FIN;
                end else begin
                    cmd_d            = calc_cmd(ag_addr, bytes_q);
                    cmd_d.trans_type = (test_mode_q != READ_ONLY);
                    cmd_d.data_mode  = data_mode_q;
                    cmd_d.data_ptrn  = data_ptrn_q;
                    cmd_valid_d      = 1'b1;
                    state_d          = (test_mode_q == READ_ONLY) ? ISSUE_RD : ISSUE_WR;
                end
            end
            ISSUE_WR: begin
                if (stop_i) stop_pend_d = 1'b1;
                if (xfer) begin
                    if (stop_any) begin
                        cmd_valid_d = 1'b0;
                        state_d     = FIN;
                    end else if (test_mode_q == WRITE_AND_CHECK) begin
                        // Read follows with identical fields
                        cmd_d.trans_type = 1'b0;
                        state_d          = ISSUE_RD;
                    end else begin
                        cmd_valid_d = 1'b0;
                        state_d     = NEXT;
                    end
                end
            end
            ISSUE_RD: begin
                if (stop_i) stop_pend_d = 1'b1;
                if (xfer) begin
                    cmd_valid_d = 1'b0;
                    state_d     = stop_any ? FIN : NEXT;
                end
            end
            NEXT: begin
                iter_d  = iter_q + 32'd1;
                state_d = (stop_i || (iter_d == count_q)) ? FIN : LOAD;
            end
            FIN: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                stop_pend_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, latched settings and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            test_mode_q <= TM_NONE;
            addr_mode_q <= FIX_ADDR;
            data_mode_q <= DM_FIXED;
            data_ptrn_q <= '0;
            bytes_q     <= '0;
            count_q     <= '0;
            iter_q      <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            test_mode_q <= test_mode_d;
            addr_mode_q <= addr_mode_d;
            data_mode_q <= data_mode_d;
            data_ptrn_q <= data_ptrn_d;
            bytes_q     <= bytes_d;
            count_q     <= count_d;
            iter_q      <= iter_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_o       = cmd_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign iter_cnt_o  = iter_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer with a command scoreboard.
module tb_test_sequencer;
    import rtl_settings_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_n_i = 1'b0;
    logic                     start_i = 1'b0;
    logic                     stop_i = 1'b0;
    test_mode_t               test_mode_i = TM_NONE;
    addr_mode_t               addr_mode_i = FIX_ADDR;
    data_mode_t               data_mode_i = DM_FIXED;
    logic [7:0]               data_ptrn_i = '0;
    logic [ADDR_W-1:0]        start_addr_i = '0;
    logic [BURST_BYTES_W-1:0] burst_bytes_i = '0;
    logic [31:0]              trans_count_i = '0;
    logic                     cmd_valid_o;
    logic                     cmd_ready_i = 1'b1;
    cmp_struct_t              cmd_o;
    logic                     busy_o;
    logic                     done_o;
    logic [31:0]              iter_cnt_o;

    int          checks = 0;
    int          errors = 0;
    int          n_acc  = 0;
    int          n_done = 0;
    cmp_struct_t sb[$];
    cmp_struct_t exp_c;

    test_sequencer dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .test_mode_i   (test_mode_i),
        .addr_mode_i   (addr_mode_i),
        .data_mode_i   (data_mode_i),
        .data_ptrn_i   (data_ptrn_i),
        .start_addr_i  (start_addr_i),
        .burst_bytes_i (burst_bytes_i),
        .trans_count_i (trans_count_i),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_ready_i   (cmd_ready_i),
        .cmd_o         (cmd_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .iter_cnt_o    (iter_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference Galois step for x^32+x^22+x^2+x+1
    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) begin
            r[31] = ~r[31];
            r[21] = ~r[21];
            r[1]  = ~r[1];
            r[0]  = ~r[0];
        end
        return r;
    endfunction

    // Push the expected command stream of a whole run
    task automatic push_run(input test_mode_t tm, input addr_mode_t am, input data_mode_t dm,
                            input logic [7:0] pt, input logic [31:0] sa,
                            input logic [11:0] bb, input logic [31:0] cnt);
        logic [31:0] b, a, e, a_inc, lf;
        logic [27:0] w;
        cmp_struct_t c;
        b     = (bb == 0) ? 32'd1 : {20'd0, bb};
        a_inc = sa;
        lf    = (sa == 0) ? 32'h0000_0001 : sa;
        for (int i = 0; i < int'(cnt); i++) begin
            case (am)
                INC_ADDR:   a = a_inc;
                RND_ADDR:   a = {lf[27:0], sa[3:0]};
                RUN_1_ADDR: begin w = 28'd1 << (i % 28); a = {w, sa[3:0]}; end
                RUN_0_ADDR: begin w = ~(28'd1 << (i % 28)); a = {w, sa[3:0]}; end
                default:    a = sa;
            endcase
            e             = a + b - 32'd1;
            c.start_addr  = a[31:4];
            c.start_off   = a[3:0];
            c.end_off     = e[3:0];
            c.words_count = 8'(e[31:4] - a[31:4] + 28'd1);
            c.data_mode   = dm;
            c.data_ptrn   = pt;
            if (tm != READ_ONLY) begin c.trans_type = 1'b1; sb.push_back(c); end
            if (tm != WRITE_ONLY) begin c.trans_type = 1'b0; sb.push_back(c); end
            a_inc = a_inc + b;
            lf    = ref_lfsr(lf);
        end
    endtask

    // Pulse start with the given settings, then scramble inputs
    task automatic start_run(input test_mode_t tm, input addr_mode_t am, input data_mode_t dm,
                             input logic [7:0] pt, input logic [31:0] sa,
                             input logic [11:0] bb, input logic [31:0] cnt);
        @(posedge clk_i); #1;
        test_mode_i   = tm;
        addr_mode_i   = am;
        data_mode_i   = dm;
        data_ptrn_i   = pt;
        start_addr_i  = sa;
        burst_bytes_i = bb;
        trans_count_i = cnt;
        start_i       = 1'b1;
        n_acc         = 0;
        @(posedge clk_i); #1;
        start_i       = 1'b0;
        start_addr_i  = $urandom;
        burst_bytes_i = 12'($urandom);
        trans_count_i = $urandom;
        data_ptrn_i   = 8'($urandom);
        test_mode_i   = TM_NONE;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        chk({tag, "_done"}, 64'(seen), 64'd1);
        if (seen) chk({tag, "_busy_fall"}, 64'(busy_o), 64'd0);
        @(negedge clk_i);
        chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_i);
            if (cmd_valid_o) seen = 1'b1;
        end
        chk({tag, "_valid"}, 64'(seen), 64'd1);
    endtask

    // Scoreboard: every transfer is matched to the oldest expected command
    always @(negedge clk_i) begin
        if (rst_n_i && cmd_valid_o && cmd_ready_i) begin
            n_acc++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL extra_cmd: observed %h expected no command", cmd_o);
            end
            if (sb.size() != 0) begin
                exp_c = sb.pop_front();
                chk("cmd", 64'(cmd_o), 64'(exp_c));
            end
        end
        if (done_o) n_done++;
    end

    initial begin
        int done_before;

        // Reset values
        #2;
        chk("rst_valid", 64'(cmd_valid_o), 64'd0);
        chk("rst_cmd",   64'(cmd_o),       64'd0);
        chk("rst_busy",  64'(busy_o),      64'd0);
        chk("rst_done",  64'(done_o),      64'd0);
        chk("rst_iter",  64'(iter_cnt_o),  64'd0);
        @(negedge clk_i); @(negedge clk_i);
        rst_n_i = 1'b1;

        // Start with test mode 00 is ignored
        start_run(TM_NONE, FIX_ADDR, DM_FIXED, 8'h00, 32'h0, 12'd16, 32'd2);
        repeat (4) @(negedge clk_i);
        chk("ign_busy", 64'(busy_o), 64'd0);

        // INC, write-and-check
        push_run(WRITE_AND_CHECK, INC_ADDR, DM_INCR, 8'hA5, 32'h10, 12'd32, 32'd3);
        start_run(WRITE_AND_CHECK, INC_ADDR, DM_INCR, 8'hA5, 32'h10, 12'd32, 32'd3);
        @(negedge clk_i);
        chk("t1_busy", 64'(busy_o), 64'd1);
        wait_done(60, "t1");
        chk("t1_acc",  64'(n_acc),      64'd6);
        chk("t1_iter", 64'(iter_cnt_o), 64'd3);
        chk("t1_sb",   64'(sb.size()),  64'd0);

        // FIX, write-only, valid latency
        push_run(WRITE_ONLY, FIX_ADDR, DM_PTRN, 8'h3C, 32'h7, 12'd20, 32'd2);
        start_run(WRITE_ONLY, FIX_ADDR, DM_PTRN, 8'h3C, 32'h7, 12'd20, 32'd2);
        @(negedge clk_i);
        chk("t2_valid_n1", 64'(cmd_valid_o), 64'd0);
        @(negedge clk_i);
        chk("t2_valid_n2", 64'(cmd_valid_o), 64'd1);
        wait_done(40, "t2");
        chk("t2_sb", 64'(sb.size()), 64'd0);

        // Walking ones / zeros
        push_run(READ_ONLY, RUN_1_ADDR, DM_PRBS, 8'h11, 32'h3, 12'd16, 32'd3);
        start_run(READ_ONLY, RUN_1_ADDR, DM_PRBS, 8'h11, 32'h3, 12'd16, 32'd3);
        wait_done(40, "t3a");
        chk("t3a_sb", 64'(sb.size()), 64'd0);
        push_run(READ_ONLY, RUN_0_ADDR, DM_PRBS, 8'h22, 32'h3, 12'd16, 32'd1);
        start_run(READ_ONLY, RUN_0_ADDR, DM_PRBS, 8'h22, 32'h3, 12'd16, 32'd1);
        wait_done(40, "t3b");
        chk("t3b_sb", 64'(sb.size()), 64'd0);

        // Backpressure after two accepted writes
        push_run(WRITE_ONLY, INC_ADDR, DM_FIXED, 8'h5A, 32'h100, 12'd16, 32'd4);
        start_run(WRITE_ONLY, INC_ADDR, DM_FIXED, 8'h5A, 32'h100, 12'd16, 32'd4);
        for (int i = 0; i < 40 && n_acc < 2; i++) begin @(negedge clk_i); #1; end
        chk("bp_two_acc", 64'(n_acc), 64'd2);
        @(posedge clk_i); #1;
        cmd_ready_i = 1'b0;
        wait_valid(10, "bp");
        chk("bp_sb_len", 64'(sb.size()), 64'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_hold_valid", 64'(cmd_valid_o), 64'd1);
            if (sb.size() != 0) chk("bp_hold_cmd", 64'(cmd_o), 64'(sb[0]));
            chk("bp_hold_iter", 64'(iter_cnt_o), 64'd2);
        end
        @(posedge clk_i); #1;
        cmd_ready_i = 1'b1;
        wait_done(40, "bp");
        chk("bp_iter", 64'(iter_cnt_o), 64'd4);
        chk("bp_sb",   64'(sb.size()),  64'd0);

        // Zero transaction count
        start_run(WRITE_AND_CHECK, INC_ADDR, DM_FIXED, 8'h00, 32'h40, 12'd16, 32'd0);
        @(negedge clk_i);
        chk("z_done_n1", 64'(done_o), 64'd0);
        @(negedge clk_i);
        chk("z_done_n2", 64'(done_o), 64'd1);
        chk("z_acc",     64'(n_acc),  64'd0);

        // Stop while the write is held
        cmd_ready_i = 1'b0;
        push_run(WRITE_AND_CHECK, INC_ADDR, DM_INCR, 8'h77, 32'h20, 12'd16, 32'd1);
        void'(sb.pop_back());
        start_run(WRITE_AND_CHECK, INC_ADDR, DM_INCR, 8'h77, 32'h20, 12'd16, 32'd3);
        wait_valid(10, "st");
        @(posedge clk_i); #1;
        stop_i = 1'b1;
        @(posedge clk_i); #1;
        stop_i = 1'b0;
        @(negedge clk_i);
        chk("st_still_valid", 64'(cmd_valid_o), 64'd1);
        cmd_ready_i = 1'b1;
        wait_done(4, "st");
        chk("st_acc", 64'(n_acc),     64'd1);
        chk("st_sb",  64'(sb.size()), 64'd0);

        // Random addresses from the default seed
        push_run(READ_ONLY, RND_ADDR, DM_PRBS, 8'h99, 32'h0, 12'd16, 32'd4);
        start_run(READ_ONLY, RND_ADDR, DM_PRBS, 8'h99, 32'h0, 12'd16, 32'd4);
        wait_done(60, "rnd");
        chk("rnd_acc", 64'(n_acc),     64'd4);
        chk("rnd_sb",  64'(sb.size()), 64'd0);

        // Asynchronous reset mid-run
        cmd_ready_i = 1'b0;
        push_run(WRITE_AND_CHECK, INC_ADDR, DM_FIXED, 8'h44, 32'h40, 12'd16, 32'd10);
        start_run(WRITE_AND_CHECK, INC_ADDR, DM_FIXED, 8'h44, 32'h40, 12'd16, 32'd10);
        wait_valid(10, "ar");
        done_before = n_done;
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("ar_valid", 64'(cmd_valid_o), 64'd0);
        chk("ar_cmd",   64'(cmd_o),       64'd0);
        chk("ar_busy",  64'(busy_o),      64'd0);
        chk("ar_iter",  64'(iter_cnt_o),  64'd0);
        sb.delete();
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        cmd_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("ar_no_done", 64'(n_done), 64'(done_before));
        chk("ar_idle",    64'(busy_o), 64'd0);

        // Recovery run after reset
        push_run(READ_ONLY, FIX_ADDR, DM_FIXED, 8'h01, 32'h1234, 12'd0, 32'd1);
        start_run(READ_ONLY, FIX_ADDR, DM_FIXED, 8'h01, 32'h1234, 12'd0, 32'd1);
        wait_done(40, "rec");
        chk("rec_sb", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
- Command scheduler of the memory checker. It sequences one test run from CSR settings into a stream of per-burst commands of type cmp_struct_t.
- Commands feed the Avalon-MM transaction engine and the comparator.
- Generates the address pattern per addr_mode_t, splits each burst into word address, byte offsets and word count, and orders write/read commands per test_mode_t.
- Owns start/stop, busy and done signalling toward the CSR block.

Parameters:
- All widths come from rtl_settings_pkg: ADDR_W, AMM_ADDR_W, AMM_BURST_W, ADDR_B_W, DATA_B_W.
- LFSR_SEED, 32'h0000_0001, seed used when the start address is zero in RND_ADDR mode.

Ports:
- clk_i, in, 1: system clock.
- rst_n_i, in, 1: asynchronous active-low reset.
- start_i, in, 1: single-cycle pulse; start a run (honoured only in IDLE).
- stop_i, in, 1: single-cycle pulse; abort the run.
- test_mode_i, in, test_mode_t: READ_ONLY / WRITE_ONLY / WRITE_AND_CHECK.
- addr_mode_i, in, addr_mode_t: address pattern.
- data_mode_i, in, data_mode_t: forwarded into each command.
- data_ptrn_i, in, 8: forwarded into each command.
- start_addr_i, in, ADDR_W: byte start address.
- burst_bytes_i, in, AMM_BURST_W+ADDR_B_W: bytes per burst; 0 is treated as 1.
- trans_count_i, in, 32: number of address iterations.
- cmd_valid_o, out, 1: command valid.
- cmd_ready_i, in, 1: command accepted.
- cmd_o, out, cmp_struct_t: command. trans_type 1 = write, 0 = read.
- busy_o, out, 1: high from start accept until done/abort.
- done_o, out, 1: one-cycle pulse at run end (normal or aborted).
- iter_cnt_o, out, 32: completed iterations.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE, LFSR is set to LFSR_SEED, counters are cleared. A reset mid-run drops any pending command with no done pulse.
- All settings are latched on start accept. Input changes during a run are ignored.
- FSM: IDLE -> LOAD -> ISSUE_WR / ISSUE_RD -> NEXT -> (LOAD or FIN) -> IDLE.
- IDLE:
  - start_i with test_mode_i == 2'b00 is ignored.
  - start_i with trans_count_i == 0 goes to FIN: done_o pulses 2 cycles after start, and no command is issued.
- LOAD: computes the iteration byte address A into a register.
  - Start accepted at cycle N -> cmd_valid_o rises at N+2.
- Address patterns. W = word address bits, ADDR_W-1 : ADDR_B_W. Byte offset = start_addr_i[ADDR_B_W-1:0] in every mode.
  - FIX_ADDR: A = start_addr_i.
  - INC_ADDR: A += burst_bytes each iteration, modulo 2^ADDR_W (wrap silently).
  - RND_ADDR: W = LFSR[AMM_ADDR_W-1:0].
    - LFSR is 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
    - Seeded from zero-extended start_addr_i, or LFSR_SEED if that is 0.
    - Advances once per NEXT.
  - RUN_1_ADDR: W = 1 << k.
  - RUN_0_ADDR: W = ~(1 << k).
  - For both RUN modes, k starts at 0, increments per iteration and wraps AMM_ADDR_W-1 -> 0.
- Command fields, with E = A + burst_bytes - 1 (ADDR_W wide, wrapping):
  - start_addr = A[ADDR_W-1:ADDR_B_W]
  - start_off = A[ADDR_B_W-1:0]
  - end_off = E[ADDR_B_W-1:0]
  - words_count = (E>>ADDR_B_W) - (A>>ADDR_B_W) + 1, truncated to AMM_BURST_W
  - data_mode and data_ptrn come from the latched settings.
  - CSR guarantees burst_bytes <= (2^AMM_BURST_W - 2)*DATA_B_W.
- Order per iteration:
  - WRITE_ONLY: ISSUE_WR.
  - READ_ONLY: ISSUE_RD.
  - WRITE_AND_CHECK: ISSUE_WR then ISSUE_RD, same fields except trans_type.
- Handshake: cmd_o is registered. cmd_o and cmd_valid_o stay stable while cmd_valid_o && !cmd_ready_i. A transfer occurs when both are high.
  - After a WR accept in WRITE_AND_CHECK, the RD command is valid the next cycle.
- NEXT: iter_cnt_o increments. If iter_cnt_o == trans_count, go to FIN, else LOAD.
- FIN: done_o = 1 for one cycle, busy_o falls the same cycle, return to IDLE.
- stop_i:
  - In LOAD or NEXT: go to FIN immediately.
  - In ISSUE_*: the pending command completes its handshake (it is never withdrawn), then FIN. A WRITE_AND_CHECK read is not issued.
  - stop_i in IDLE is ignored.
  - If start_i and stop_i arrive in the same cycle in IDLE, start wins.

Decomposition:
- Add to rtl_settings_pkg:
  - typedef seq_state_t (IDLE, LOAD, ISSUE_WR, ISSUE_RD, NEXT, FIN).
  - LFSR polynomial constant 32'h8020_0003.
  - Function calc_cmd(A, burst_bytes) returning the cmp_struct_t address/offset/count fields. The comparator model reuses it.
- One sub-module: addr_gen (pattern registers, LFSR, k counter; load/advance inputs, byte address output).

Test Plan:
- INC, WRITE_AND_CHECK, start 32'h10, bytes 32, count 3, ready=1 -> W/R pairs on word addr 1, 3, 5; so=0, eo=15, wc=2; done_o after 6th accept; iter_cnt_o=3.
- FIX, WRITE_ONLY, start 32'h7, bytes 20, count 2 -> two writes: addr 0, so=7, eo=10, wc=2; first cmd_valid_o at start+2.
- RUN_1, READ_ONLY, start 32'h3, count 3 -> reads at word addr 1, 2, 4 with so=3. RUN_0, count 1 -> word addr 28'hFFF_FFFE.
- Backpressure: cmd_ready_i low 5 cycles mid-run -> cmd_o/cmd_valid_o stable, iter_cnt_o frozen; resumes on ready.
- trans_count 0 -> no commands, done_o 2 cycles after start. stop_i during held write in WRITE_AND_CHECK -> write completes, no read, done_o next cycle.
- RND, start 32'h0, count 4 -> word addresses match the LFSR_SEED reference model. rst_n_i low mid-run -> all outputs 0 asynchronously, no done_o.
